// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a length-prefixed, XOR-checksummed byte
// stream, writes the words into instruction memory, then releases the core from reset.
module imem_loader #(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_write_en,
  output logic [31:0] imem_write_addr,
  output logic [31:0] imem_write_data,
  output logic        core_reset,
  output logic        imem_read_en,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {HDR, DATA, CSUM, RUN, ERROR} state_t;

  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  state_t      r_state;
  logic [31:0] r_count;
  logic [31:0] r_wordIdx;
  logic [31:0] r_word;
  logic [1:0]  r_byteIdx;
  logic [7:0]  r_csum;

  logic        w_accept;
  logic [31:0] w_count;
  logic [31:0] w_word;
  logic [31:0] w_addr;
  logic [31:0] w_wordNext;

  assign w_accept   = byte_valid && byte_ready;
  assign w_count    = {byte_data, r_count[31:8]};
  assign w_addr     = BASE_ADDR + (r_wordIdx << 2);
  assign w_wordNext = r_wordIdx + 32'd1;

  always_comb begin
    w_word = r_word;
    w_word[{r_byteIdx, 3'b000} +: 8] = byte_data;
  end

  // Outputs are set from the next state so they change on the same edge as r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= HDR;
      r_count         <= '0;
      r_wordIdx       <= '0;
      r_word          <= '0;
      r_byteIdx       <= '0;
      r_csum          <= '0;
      byte_ready      <= 1'b1;
      imem_write_en   <= 1'b0;
      imem_write_addr <= '0;
      imem_write_data <= '0;
      core_reset      <= 1'b1;
      imem_read_en    <= 1'b0;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
    end else begin
      imem_write_en <= 1'b0;
      if (w_accept) begin
        case (r_state)
          HDR: begin
            r_count   <= w_count;
            r_byteIdx <= r_byteIdx + 2'd1;
            if (r_byteIdx == 2'd3) begin
              if (w_count == 32'd0 || w_count > MAX_N) begin
                r_state    <= ERROR;
                byte_ready <= 1'b0;
                load_error <= 1'b1;
              end else begin
                r_state <= DATA;
              end
            end
          end
          DATA: begin
            r_word    <= w_word;
            r_csum    <= r_csum ^ byte_data;
            r_byteIdx <= r_byteIdx + 2'd1;
            if (r_byteIdx == 2'd3) begin
              imem_write_en   <= 1'b1;
              imem_write_addr <= w_addr;
              imem_write_data <= w_word;
              r_wordIdx       <= w_wordNext;
              if (w_wordNext == r_count) begin
                r_state <= CSUM;
              end
            end
          end
          CSUM: begin
            byte_ready <= 1'b0;
            if (byte_data == r_csum) begin
              r_state      <= RUN;
              core_reset   <= 1'b0;
              imem_read_en <= 1'b1;
              load_done    <= 1'b1;
            end else begin
              r_state    <= ERROR;
              load_error <= 1'b1;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: nominal, bad checksum, bad length,
// maximum length, reset mid-load and no-accept-after-done scenarios.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_write_en;
  logic [31:0] imem_write_addr;
  logic [31:0] imem_write_data;
  logic        core_reset;
  logic        imem_read_en;
  logic        load_done;
  logic        load_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];

  logic [7:0]  nominalStream [0:11];
  logic [31:0] maxWords [0:255];
  logic [7:0]  maxCsum;

  imem_loader #(
    .MAX_WORDS(256),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .imem_write_en  (imem_write_en),
    .imem_write_addr(imem_write_addr),
    .imem_write_data(imem_write_data),
    .core_reset     (core_reset),
    .imem_read_en   (imem_read_en),
    .load_done      (load_done),
    .load_error     (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle with the strobe high is one write; a stuck strobe shows up as extra writes.
  always @(negedge clk) begin
    if (imem_write_en === 1'b1) begin
      wrAddrQ.push_back(imem_write_addr);
      wrDataQ.push_back(imem_write_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int maxGap);
    if (maxGap > 0) repeat ($urandom_range(0, maxGap)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset      = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wrAddrQ.delete();
    wrDataQ.delete();
  endtask

  task automatic sendNominal(input logic [7:0] csum, input int maxGap);
    for (int i = 0; i < 12; i++) applyStimulus(nominalStream[i], maxGap);
    applyStimulus(csum, maxGap);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"},    32'(byte_ready),      32'd1);
    checkOutput({tag, "_wren"},     32'(imem_write_en),   32'd0);
    checkOutput({tag, "_addr"},     imem_write_addr,      32'd0);
    checkOutput({tag, "_data"},     imem_write_data,      32'd0);
    checkOutput({tag, "_corerst"},  32'(core_reset),      32'd1);
    checkOutput({tag, "_rden"},     32'(imem_read_en),    32'd0);
    checkOutput({tag, "_done"},     32'(load_done),       32'd0);
    checkOutput({tag, "_err"},      32'(load_error),      32'd0);
  endtask

  initial begin
    logic [7:0] b;
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    nominalStream = '{8'h02, 8'h00, 8'h00, 8'h00,
                      8'h13, 8'h00, 8'h00, 8'h00,
                      8'h93, 8'h00, 8'h10, 8'h00};

    doReset();
    checkResetState("rst");

    // Nominal load: core still held until the checksum byte lands.
    for (int i = 0; i < 12; i++) applyStimulus(nominalStream[i], 0);
    checkOutput("nom_pre_corerst", 32'(core_reset), 32'd1);
    checkOutput("nom_pre_ready",   32'(byte_ready), 32'd1);
    applyStimulus(8'h90, 0);
    checkOutput("nom_done",    32'(load_done),    32'd1);
    checkOutput("nom_corerst", 32'(core_reset),   32'd0);
    checkOutput("nom_rden",    32'(imem_read_en), 32'd1);
    checkOutput("nom_ready",   32'(byte_ready),   32'd0);
    checkOutput("nom_err",     32'(load_error),   32'd0);
    checkOutput("nom_wrcount", 32'(wrAddrQ.size()), 32'd2);
    checkOutput("nom_addr0",   wrAddrQ[0], 32'h0000_0000);
    checkOutput("nom_data0",   wrDataQ[0], 32'h0000_0013);
    checkOutput("nom_addr1",   wrAddrQ[1], 32'h0000_0004);
    checkOutput("nom_data1",   wrDataQ[1], 32'h0010_0093);

    // Hold byte_valid high in RUN: nothing may be accepted or change.
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (10) @(negedge clk);
    byte_valid = 1'b0;
    checkOutput("run_wrcount", 32'(wrAddrQ.size()), 32'd2);
    checkOutput("run_ready",   32'(byte_ready),   32'd0);
    checkOutput("run_done",    32'(load_done),    32'd1);
    checkOutput("run_corerst", 32'(core_reset),   32'd0);
    checkOutput("run_rden",    32'(imem_read_en), 32'd1);
    checkOutput("run_err",     32'(load_error),   32'd0);

    // Bad checksum.
    doReset();
    checkResetState("rst2");
    sendNominal(8'h91, 0);
    checkOutput("csum_wrcount", 32'(wrAddrQ.size()), 32'd2);
    checkOutput("csum_err",     32'(load_error),   32'd1);
    checkOutput("csum_corerst", 32'(core_reset),   32'd1);
    checkOutput("csum_ready",   32'(byte_ready),   32'd0);
    checkOutput("csum_done",    32'(load_done),    32'd0);
    checkOutput("csum_rden",    32'(imem_read_en), 32'd0);

    // Zero length; trailing bytes must not produce writes.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(8'h00, 0);
    checkOutput("len0_err",   32'(load_error), 32'd1);
    checkOutput("len0_ready", 32'(byte_ready), 32'd0);
    for (int i = 4; i < 12; i++) applyStimulus(nominalStream[i], 0);
    checkOutput("len0_wrcount", 32'(wrAddrQ.size()), 32'd0);
    checkOutput("len0_corerst", 32'(core_reset), 32'd1);

    // N = 257 is one past the limit.
    doReset();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    checkOutput("len257_pre_err", 32'(load_error), 32'd0);
    applyStimulus(8'h00, 0);
    checkOutput("len257_err",     32'(load_error), 32'd1);
    checkOutput("len257_wrcount", 32'(wrAddrQ.size()), 32'd0);

    // Huge N only visible in the top header byte.
    doReset();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h80, 0);
    checkOutput("lenbig_err", 32'(load_error), 32'd1);

    // Maximum length N = 256 with random payload.
    doReset();
    maxCsum = 8'h00;
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    checkOutput("max_hdr_err", 32'(load_error), 32'd0);
    for (int w = 0; w < 256; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom_range(0, 255));
        maxWords[w][8*k +: 8] = b;
        maxCsum = maxCsum ^ b;
        applyStimulus(b, 0);
      end
    end
    checkOutput("max_pre_done", 32'(load_done), 32'd0);
    applyStimulus(maxCsum, 0);
    checkOutput("max_wrcount", 32'(wrAddrQ.size()), 32'd256);
    for (int w = 0; w < 256; w++) begin
      checkOutput($sformatf("max_addr%0d", w), wrAddrQ[w], 32'(w * 4));
      checkOutput($sformatf("max_data%0d", w), wrDataQ[w], maxWords[w]);
    end
    checkOutput("max_lastaddr", wrAddrQ[255], 32'h0000_03FC);
    checkOutput("max_done",     32'(load_done),  32'd1);
    checkOutput("max_err",      32'(load_error), 32'd0);

    // Reset after 6 accepted bytes, then a full stream with random gaps.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(nominalStream[i], 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_ready",   32'(byte_ready), 32'd1);
    checkOutput("mid_corerst", 32'(core_reset), 32'd1);
    sendNominal(8'h90, 3);
    checkOutput("mid_wrcount", 32'(wrAddrQ.size()), 32'd2);
    checkOutput("mid_addr0",   wrAddrQ[0], 32'h0000_0000);
    checkOutput("mid_data0",   wrDataQ[0], 32'h0000_0013);
    checkOutput("mid_addr1",   wrAddrQ[1], 32'h0000_0004);
    checkOutput("mid_data1",   wrDataQ[1], 32'h0010_0093);
    checkOutput("mid_done",    32'(load_done),    32'd1);
    checkOutput("mid_rden",    32'(imem_read_en), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256; the largest accepted program length in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000; the byte address of the first instruction word written.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port byte_valid, input, 1 bit: the upstream byte source has a byte on byte_data.
REQ-006 SHALL have port byte_data, input, 8 bits: the byte of the program stream.
REQ-007 SHALL have port byte_ready, output, 1 bit: the loader can accept a byte this cycle.
REQ-008 SHALL have port imem_write_en, output, 1 bit: one-cycle instruction-memory write strobe.
REQ-009 SHALL have port imem_write_addr, output, 32 bits: the byte address for the write.
REQ-010 SHALL have port imem_write_data, output, 32 bits: the instruction word to write.
REQ-011 SHALL have port core_reset, output, 1 bit: drives the core's reset; the core is held in reset while this is high.
REQ-012 SHALL have port imem_read_en, output, 1 bit: drives the core's instruction fetch enable.
REQ-013 SHALL have port load_done, output, 1 bit: the program loaded and its checksum verified.
REQ-014 SHALL have port load_error, output, 1 bit: the load was aborted because of a bad length or a bad checksum.

Function
REQ-015 SHALL accept a byte only in a cycle where byte_valid and byte_ready are both 1; there is no other acceptance path.
REQ-016 SHALL expect this stream format:
- a 4-byte header holding word count N, little-endian;
- N words of 4 bytes each, little-endian;
- 1 checksum byte equal to the XOR of all 4N payload bytes.
REQ-017 SHALL implement the FSM states HDR, DATA, CSUM, RUN and ERROR; reset enters HDR.
REQ-018 SHALL, in HDR, shift accepted bytes into the count register; on the 4th byte:
- if N==0 or N>MAX_WORDS, go to ERROR;
- otherwise go to DATA.
REQ-019 SHALL, in DATA, place accepted byte k (k=0..3) into bits [8k+7:8k] of the word register and XOR it into the checksum register.
REQ-020 SHALL, in the cycle after the 4th byte of word i is accepted, pulse imem_write_en for exactly one cycle with:
- imem_write_addr = BASE_ADDR + 4*i;
- imem_write_data = the assembled word.
REQ-021 SHALL go from DATA to CSUM when the 4th byte of word N-1 is accepted; the word counter SHALL never exceed N.
REQ-022 SHALL, in CSUM, compare the accepted byte to the checksum register: equal goes to RUN, unequal goes to ERROR.
REQ-023 SHALL drive byte_ready=1 in HDR, DATA and CSUM, and byte_ready=0 in RUN and ERROR.
REQ-024 SHALL drive core_reset=1 and imem_read_en=0 in every state except RUN.
REQ-025 SHALL drive, in RUN, core_reset=0, imem_read_en=1 and load_done=1; RUN is left only by reset.
REQ-026 SHALL drive load_error=1 only in ERROR; ERROR is left only by reset, and no imem writes occur in it.
REQ-027 SHALL register all outputs; core_reset falls and load_done rises in the first cycle the state register holds RUN.
REQ-028 SHALL hold all partial counters unchanged when byte_valid is low mid-word; gaps between bytes of any length are legal.
REQ-029 SHALL compute write addresses modulo 2^32 with no overflow detection.

Reset
REQ-030 SHALL, while reset=1 at a clock edge, set the following on the next cycle:
- state=HDR;
- count, word index, byte index, word register and checksum all cleared;
- imem_write_en=0, imem_write_addr=0, imem_write_data=0;
- core_reset=1, imem_read_en=0, load_done=0, load_error=0, byte_ready=1.
REQ-031 SHALL, on reset asserted mid-load, discard all partial progress; a following complete stream SHALL load starting at BASE_ADDR.

Verification
REQ-032 SHALL be verified by the nominal-load scenario:
- stimulus: stream 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | 90;
- response: write (0x0, 0x00000013), then write (0x4, 0x00100093), then load_done=1, core_reset=0, imem_read_en=1.
REQ-033 SHALL be verified by the bad-checksum scenario:
- stimulus: the same stream with checksum 91;
- response: two writes, then load_error=1, core_reset stays 1, byte_ready=0.
REQ-034 SHALL be verified by the bad-length scenario:
- stimulus: header 00 00 00 00, and separately header 01 01 00 00 (N=257) with MAX_WORDS=256;
- response: ERROR right after the 4th header byte, zero writes.
REQ-035 SHALL be verified by the maximum-length scenario:
- stimulus: N=256 with random bytes and a correct checksum;
- response: exactly 256 writes, the last at address 0x3FC, then RUN.
REQ-036 SHALL be verified by the reset-mid-load scenario:
- stimulus: reset pulsed after 6 accepted bytes, then the full nominal stream with random byte_valid gaps;
- response: the same two writes as REQ-032 at 0x0 and 0x4.
REQ-037 SHALL be verified by the no-accept-after-done scenario:
- stimulus: byte_valid=1 held high after RUN is reached;
- response: byte_ready=0, no further writes, outputs stable.
